// File: rtl/imem_fetch_buffered_if.sv
// Fetch, result, redirect and program-load signals between the fetch stage and
// the buffered instruction memory.
interface imem_fetch_buffered_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_req;
  logic [31:0]           fetch_pc;
  logic                  fetch_ready;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [31:0]           instr_pc;
  logic                  fault_misaligned;
  logic                  fault_range;
  logic                  flush;
  logic                  load_start;
  logic                  load_we;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_done;
  logic                  load_active;
  logic                  load_overflow;
  logic                  parity_err;

  modport master (
    output fetch_req, fetch_pc, instr_ready, flush,
           load_start, load_we, load_data, load_done,
    input  fetch_ready, instr_valid, instr, instr_pc, fault_misaligned,
           fault_range, load_active, load_overflow, parity_err
  );

  modport slave (
    input  fetch_req, fetch_pc, instr_ready, flush,
           load_start, load_we, load_data, load_done,
    output fetch_ready, instr_valid, instr, instr_pc, fault_misaligned,
           fault_range, load_active, load_overflow, parity_err
  );
endinterface

// File: rtl/imem_fetch_buffered.sv
// Instruction memory with a one-cycle valid/ready fetch, flush and a sequential
// run-time program loader. Define IMEM_PARITY_EN to store and check even parity.
module imem_fetch_buffered #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h0000_0000)
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_fetch_buffered_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {RUN, LOAD} state_t;

  state_t                  state;
  // Extra MSB marks "last word written"; further writes only raise overflow.
  logic [ADDR_WIDTH:0]     cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    f_mis, f_rng, fault, accept, wr_en;

  assign rd_idx = bus.fetch_pc[ADDR_WIDTH+1:2];
  assign f_mis  = bus.fetch_pc[1:0] != 2'b00;
  assign f_rng  = (bus.fetch_pc >> (ADDR_WIDTH+2)) != 32'd0;
  assign fault  = f_mis || f_rng;

  assign bus.fetch_ready = (state == RUN) && !bus.load_start &&
                           (!bus.instr_valid || bus.instr_ready || bus.flush);
  assign accept      = bus.fetch_req && bus.fetch_ready;
  assign wr_en       = (state == LOAD) && !bus.load_start && bus.load_we && !cnt[ADDR_WIDTH];
  assign bus.load_active = (state == LOAD);

  always_ff @(posedge clk)
    if (wr_en) mem[cnt[ADDR_WIDTH-1:0]] <= bus.load_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      cnt               <= '0;
      bus.load_overflow <= 1'b0;
    end else if (bus.load_start) begin
      state             <= LOAD;
      cnt               <= '0;
      bus.load_overflow <= 1'b0;
    end else if (state == LOAD) begin
      if (bus.load_we) begin
        if (!cnt[ADDR_WIDTH]) cnt <= cnt + (ADDR_WIDTH+1)'(1);
        else                  bus.load_overflow <= 1'b1;
      end
      if (bus.load_done) state <= RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.instr_valid      <= 1'b0;
      bus.instr            <= '0;
      bus.instr_pc         <= '0;
      bus.fault_misaligned <= 1'b0;
      bus.fault_range      <= 1'b0;
    end else if (accept) begin
      bus.instr_valid      <= 1'b1;
      bus.instr            <= fault ? NOP_WORD : mem[rd_idx];
      bus.instr_pc         <= bus.fetch_pc;
      bus.fault_misaligned <= f_mis;
      bus.fault_range      <= f_rng;
    end else if (bus.instr_valid && (bus.instr_ready || bus.flush)) begin
      bus.instr_valid      <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge clk)
    if (wr_en) mem_par[cnt[ADDR_WIDTH-1:0]] <= ^bus.load_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.parity_err <= 1'b0;
    else if (accept)
      bus.parity_err <= !fault && ((^mem[rd_idx]) != mem_par[rd_idx]);
    else if (bus.instr_valid && (bus.instr_ready || bus.flush))
      bus.parity_err <= 1'b0;
  end
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_imem_fetch_buffered.sv
// Randomized bench for imem_fetch_buffered: a queue/array reference model is
// compared every cycle, plus literal checks and a small ADDR_WIDTH=2 instance.
module tb_imem_fetch_buffered;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_fetch_buffered_if #(.DATA_WIDTH(32)) m_if();
  imem_fetch_buffered_if #(.DATA_WIDTH(32)) s_if();

  imem_fetch_buffered #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(m_if.slave));
  imem_fetch_buffered #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut_s (
    .clk(clk), .reset(rst2), .bus(s_if.slave));

  // Reference model state (main instance)
  logic [31:0] mm   [DEPTH];
  bit          mk   [DEPTH];
  bit          mbad [DEPTH];
  bit          e_run = 1, e_ovf = 0, e_valid = 0, e_mis = 0, e_rng = 0, e_known = 0, e_par = 0;
  int          e_cnt = 0;
  logic [31:0] e_instr = 0, e_pc = 0;

  logic [31:0] prog [14] = '{32'h8C020000, 32'h00001820, 32'h20630001, 32'h00431020,
                             32'hAC020004, 32'h1060FFFB, 32'h00000000, 32'h8C040008,
                             32'h00852020, 32'h2084FFFF, 32'h14800002, 32'h08000000,
                             32'hAC040010, 32'h0000000C};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_ready();
    return e_run && !m_if.load_start && (!e_valid || m_if.instr_ready || m_if.flush);
  endfunction

  // Model: one step per clock edge from the interface rules
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      e_run = 1; e_cnt = 0; e_ovf = 0; e_valid = 0; e_instr = 0; e_pc = 0;
      e_mis = 0; e_rng = 0; e_known = 0; e_par = 0;
    end else begin
      bit rdy;
      rdy = exp_ready();
      if (m_if.fetch_req && rdy) begin
        int idx;
        idx     = (m_if.fetch_pc / 4) % DEPTH;
        e_valid = 1;
        e_pc    = m_if.fetch_pc;
        e_mis   = (m_if.fetch_pc % 4) != 0;
        e_rng   = m_if.fetch_pc >= DEPTH * 4;
        e_instr = (e_mis || e_rng) ? 32'h0 : mm[idx];
        e_known = e_mis || e_rng || mk[idx];
        e_par   = !(e_mis || e_rng) && mbad[idx];
      end else if (e_valid && (m_if.instr_ready || m_if.flush)) begin
        e_valid = 0; e_par = 0;
      end
      if (m_if.load_start) begin
        e_run = 0; e_cnt = 0; e_ovf = 0;
      end else if (!e_run) begin
        if (m_if.load_we) begin
          if (e_cnt < DEPTH) begin
            mm[e_cnt] = m_if.load_data; mk[e_cnt] = 1; mbad[e_cnt] = 0; e_cnt++;
          end else e_ovf = 1;
        end
        if (m_if.load_done) e_run = 1;
      end
    end
  end

  // Every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("fetch_ready", 32'(m_if.fetch_ready), 32'(exp_ready()));
    chk("instr_valid", 32'(m_if.instr_valid), 32'(e_valid));
    chk("load_active", 32'(m_if.load_active), 32'(!e_run));
    chk("load_overflow", 32'(m_if.load_overflow), 32'(e_ovf));
    chk("parity_err", 32'(m_if.parity_err), 32'(e_valid && e_par));
    if (e_valid) begin
      chk("instr_pc", m_if.instr_pc, e_pc);
      chk("fault_misaligned", 32'(m_if.fault_misaligned), 32'(e_mis));
      chk("fault_range", 32'(m_if.fault_range), 32'(e_rng));
      if (e_known) chk("instr", m_if.instr, e_instr);
    end
  end

  task automatic fetch(input logic [31:0] pc);
    m_if.fetch_req = 1; m_if.fetch_pc = pc; cyc(); m_if.fetch_req = 0;
  endtask

  initial begin
    m_if.fetch_req = 0; m_if.fetch_pc = 0; m_if.instr_ready = 1; m_if.flush = 0;
    m_if.load_start = 0; m_if.load_we = 0; m_if.load_data = 0; m_if.load_done = 0;
    s_if.fetch_req = 0; s_if.fetch_pc = 0; s_if.instr_ready = 1; s_if.flush = 0;
    s_if.load_start = 0; s_if.load_we = 0; s_if.load_data = 0; s_if.load_done = 0;
    cyc(); cyc();
    chk("rst_instr", m_if.instr, 32'h0);
    chk("rst_instr_pc", m_if.instr_pc, 32'h0);
    chk("rst_valid", 32'(m_if.instr_valid), 32'h0);
    reset = 0; rst2 = 0;
    cyc();

    // 14-word program load then sequential fetch
    m_if.load_start = 1; cyc(); m_if.load_start = 0;
    chk("load_active_on", 32'(m_if.load_active), 32'h1);
    for (int i = 0; i < 14; i++) begin
      m_if.load_we = 1; m_if.load_data = prog[i]; cyc();
    end
    m_if.load_we = 0; m_if.load_done = 1; cyc(); m_if.load_done = 0;
    chk("load_active_off", 32'(m_if.load_active), 32'h0);
    for (int i = 0; i < 14; i++) begin
      m_if.fetch_req = 1; m_if.fetch_pc = 32'(i * 4); cyc();
      chk("seq_instr", m_if.instr, prog[i]);
      chk("seq_pc", m_if.instr_pc, 32'(i * 4));
    end
    m_if.fetch_req = 0; cyc();

    // Stall hold then release into a new fetch
    m_if.instr_ready = 0; fetch(32'h10);
    chk("stall_first", m_if.instr, 32'h20630001 ^ 32'h20630001 ^ prog[4]);
    m_if.fetch_req = 1; m_if.fetch_pc = 32'h14;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", m_if.instr_pc, 32'h10);
      chk("stall_instr", m_if.instr, 32'hAC020004);
      chk("stall_ready", 32'(m_if.fetch_ready), 32'h0);
    end
    m_if.instr_ready = 1; cyc(); m_if.fetch_req = 0;
    chk("release_pc", m_if.instr_pc, 32'h14);
    chk("release_instr", m_if.instr, 32'h1060FFFB);
    cyc();

    // Faults
    fetch(32'h12);
    chk("mis_instr", m_if.instr, 32'h0);
    chk("mis_flag", 32'(m_if.fault_misaligned), 32'h1);
    fetch(32'h400);
    chk("rng_flag", 32'(m_if.fault_range), 32'h1);
    chk("rng_instr", m_if.instr, 32'h0);
    fetch(32'h402);
    chk("both_flags", {30'h0, m_if.fault_range, m_if.fault_misaligned}, 32'h3);
    cyc();

    // Full load with one write past the end
    m_if.load_start = 1; cyc(); m_if.load_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_if.load_we = 1; m_if.load_data = $urandom; cyc();
    end
    chk("ovf_before", 32'(m_if.load_overflow), 32'h0);
    m_if.load_data = 32'hDEADBEEF; cyc();
    chk("ovf_after", 32'(m_if.load_overflow), 32'h1);
    m_if.load_we = 0; m_if.load_done = 1; cyc(); m_if.load_done = 0;

    // Flush with and without a replacing fetch
    m_if.instr_ready = 0; fetch(32'h20);
    chk("flush_pre_pc", m_if.instr_pc, 32'h20);
    m_if.flush = 1; m_if.fetch_req = 1; m_if.fetch_pc = 32'h50; cyc();
    chk("flush_new_valid", 32'(m_if.instr_valid), 32'h1);
    chk("flush_new_pc", m_if.instr_pc, 32'h50);
    m_if.fetch_req = 0; cyc();
    chk("flush_alone", 32'(m_if.instr_valid), 32'h0);
    m_if.flush = 0; m_if.instr_ready = 1; cyc();

    // Randomized traffic including occasional reloads
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      int r;
      r  = $urandom_range(7);
      pc = 32'($urandom_range(DEPTH - 1)) << 2;
      if (r == 0) pc = pc + 32'($urandom_range(3, 1));
      if (r == 1) pc = pc | (32'($urandom_range(1000, 1)) << 10);
      m_if.fetch_req   = ($urandom_range(3) != 0);
      m_if.fetch_pc    = pc;
      m_if.instr_ready = ($urandom_range(2) != 0);
      m_if.flush       = ($urandom_range(7) == 0);
      m_if.load_start  = ($urandom_range(99) == 0);
      m_if.load_we     = ($urandom_range(3) == 0);
      m_if.load_data   = $urandom;
      m_if.load_done   = ($urandom_range(15) == 0);
      cyc();
    end
    m_if.fetch_req = 0; m_if.flush = 0; m_if.instr_ready = 1;
    m_if.load_start = 0; m_if.load_we = 0; m_if.load_done = 1; cyc();
    m_if.load_done = 0; cyc();

`ifdef IMEM_PARITY_EN
    dut.mem[2] = dut.mem[2] ^ 32'h0000_0100;
    mm[2] = mm[2] ^ 32'h0000_0100; mbad[2] = 1;
    fetch(32'h8);
    chk("parity_flag", 32'(m_if.parity_err), 32'h1);
    chk("parity_instr", m_if.instr, mm[2]);
    cyc();
`else
    fetch(32'h8);
    chk("parity_off", 32'(m_if.parity_err), 32'h0);
    cyc();
`endif

    // Reset during a pending result
    m_if.instr_ready = 0; fetch(32'h4);
    chk("pend_valid", 32'(m_if.instr_valid), 32'h1);
    reset = 1; #1;
    chk("rst_drop_valid", 32'(m_if.instr_valid), 32'h0);
    cyc(); reset = 0; m_if.instr_ready = 1; cyc();
    fetch(32'h4); cyc();

    // Small instance: overflow and reset mid-load
    s_if.load_start = 1; cyc(); s_if.load_start = 0;
    for (int i = 0; i < 5; i++) begin
      s_if.load_we = 1; s_if.load_data = 32'hA0 + 32'(i); cyc();
      if (i == 3) chk("s_ovf_at4", 32'(s_if.load_overflow), 32'h0);
      if (i == 4) chk("s_ovf_at5", 32'(s_if.load_overflow), 32'h1);
    end
    s_if.load_we = 0; s_if.load_done = 1; cyc(); s_if.load_done = 0;
    chk("s_active_off", 32'(s_if.load_active), 32'h0);
    for (int i = 0; i < 4; i++) begin
      s_if.fetch_req = 1; s_if.fetch_pc = 32'(i * 4); cyc();
      chk("s_instr", s_if.instr, 32'hA0 + 32'(i));
    end
    s_if.fetch_pc = 32'h10; cyc(); s_if.fetch_req = 0;
    chk("s_rng", 32'(s_if.fault_range), 32'h1);
    chk("s_rng_instr", s_if.instr, 32'h0);
    cyc();
    s_if.load_start = 1; cyc(); s_if.load_start = 0;
    for (int i = 0; i < 5; i++) begin
      s_if.load_we = 1; s_if.load_data = 32'hB0 + 32'(i); cyc();
    end
    s_if.load_we = 0;
    chk("s_mid_active", 32'(s_if.load_active), 32'h1);
    chk("s_mid_ovf", 32'(s_if.load_overflow), 32'h1);
    rst2 = 1; #1;
    chk("s_rst_active", 32'(s_if.load_active), 32'h0);
    chk("s_rst_ovf", 32'(s_if.load_overflow), 32'h0);
    cyc(); rst2 = 0; cyc();
    s_if.fetch_req = 1; s_if.fetch_pc = 32'hC; cyc(); s_if.fetch_req = 0;
    chk("s_persist", s_if.instr, 32'hB3);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
